// File: rtl/wb_arbiter.sv
// Writeback arbiter: the ALU path has strict priority, and load results wait in a 2-entry FIFO.
// A registered output stage drives the register-file write port.
module wb_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic [2:0]       alu_regsel,
    input  logic [WIDTH-1:0] alu_data,
    input  logic             mem_valid,
    input  logic [2:0]       mem_regsel,
    input  logic [WIDTH-1:0] mem_data,
    output logic             mem_ready,
    output logic             write,
    output logic [2:0]       writeregsel,
    output logic [WIDTH-1:0] writedata,
    output logic [7:0]       pending,
    output logic             err
);

    logic [2:0]       r_q_sel  [2];
    logic [WIDTH-1:0] r_q_data [2];
    logic             r_head;
    logic             r_tail;
    logic [1:0]       r_count;

    logic             r_write;
    logic [2:0]       r_writeregsel;
    logic [WIDTH-1:0] r_writedata;
    logic             r_err;

    logic             w_ready;
    logic             w_enq;
    logic             w_deq;
    logic [1:0]       w_slot_valid;
    logic             w_collide;
    logic [7:0]       w_pending;

    assign w_ready = (r_count < 2'd2);
    assign w_enq   = mem_valid & w_ready;
    assign w_deq   = ~alu_valid & (r_count != 2'd0);

    always_comb begin
        w_slot_valid = 2'b00;
        w_collide    = 1'b0;
        w_pending    = 8'h00;
        for (int i = 0; i < 2; i++) begin
            w_slot_valid[i] = (r_count == 2'd2) || ((r_count == 2'd1) && (r_head == 1'(i)));
            if (w_slot_valid[i]) begin
                w_pending[r_q_sel[i]] = 1'b1;
                if (alu_valid && (r_q_sel[i] == alu_regsel)) begin
                    w_collide = 1'b1;
                end
            end
        end
        if (r_write) begin
            w_pending[r_writeregsel] = 1'b1;
        end
    end

    // Storage needs no reset; validity comes from head/count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_sel[r_tail]  <= mem_regsel;
            r_q_data[r_tail] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
            r_count       <= 2'd0;
            r_write       <= 1'b0;
            r_writeregsel <= 3'd0;
            r_writedata   <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_enq) begin
                r_tail <= ~r_tail;
            end
            if (w_deq) begin
                r_head <= ~r_head;
            end
            r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};

            if (alu_valid) begin
                r_write       <= 1'b1;
                r_writeregsel <= alu_regsel;
                r_writedata   <= alu_data;
            end else if (w_deq) begin
                r_write       <= 1'b1;
                r_writeregsel <= r_q_sel[r_head];
                r_writedata   <= r_q_data[r_head];
            end else begin
                r_write <= 1'b0;
            end

            r_err <= w_collide | (mem_valid & ~w_ready);
        end
    end

    assign mem_ready   = w_ready;
    assign write       = r_write;
    assign writeregsel = r_writeregsel;
    assign writedata   = r_writedata;
    assign pending     = w_pending;
    assign err         = r_err;

endmodule
